spi_rom_rx: RTL
===============

SPI_ROM_RX -- requirements
Module: spi_rom_rx

Interface
REQ-001 SHALL have parameter AW, default 22, meaning ioctl_addr width in bits.
REQ-002 SHALL have port clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port SPI_SCK  input  1  SPI clock from the MCU, asynchronous to clk.
REQ-005 SHALL have port SPI_DI  input  1  SPI serial data, MSB first, valid on SPI_SCK rising edge.
REQ-006 SHALL have port SPI_SS2  input  1  frame select, active-low.
REQ-007 SHALL have port ioctl_download  output  1  high while a ROM download is in progress.
REQ-008 SHALL have port ioctl_index  output  8  file index from the last FILE_INDEX command.
REQ-009 SHALL have port ioctl_addr  output  AW  byte address of the current or last write.
REQ-010 SHALL have port ioctl_dout  output  8  byte being written.
REQ-011 SHALL have port ioctl_wr  output  1  one-clk write strobe.

Function
REQ-012 SHALL pass SPI_SCK, SPI_DI and SPI_SS2 through 2-FF synchronisers before any use.
REQ-013 SHALL detect SCK rising edges on synchronised SCK; SCK high and low phases SHALL each be at least 2 clk periods; faster SCK is unsupported.
REQ-014 SHALL shift synchronised DI into an 8-bit register on each detected SCK rise while synchronised SS2 is low, MSB first; a byte is complete on the 8th rise.
REQ-015 SHALL clear the bit counter and return the frame FSM to CMD whenever synchronised SS2 is high; a partial byte SHALL be discarded with no output effect.
REQ-016 Frame FSM states: CMD (next byte is a command), TX_ARG, DAT, IDX_ARG, IGNORE; leaves CMD on first complete byte.
REQ-017 CMD byte 0x53 (FILE_TX) -> TX_ARG; 0x54 (FILE_TX_DAT) -> DAT; 0x55 (FILE_INDEX) -> IDX_ARG; any other value -> IGNORE.
REQ-018 TX_ARG byte nonzero -> ioctl_download=1, ioctl_addr=0; byte zero -> ioctl_download=0, ioctl_addr held; then -> IGNORE.
REQ-019 IDX_ARG byte -> ioctl_index=byte, then -> IGNORE.
REQ-020 DAT: each complete byte with ioctl_download=1 SHALL load ioctl_dout and pulse ioctl_wr high for exactly one clk; FSM stays in DAT.
REQ-021 DAT byte with ioctl_download=0 SHALL be dropped: no ioctl_wr, no address change.
REQ-022 ioctl_addr during an ioctl_wr pulse SHALL equal the write address; it SHALL increment by 1 on the clk after the pulse, so it equals bytes-written after the last write.
REQ-023 ioctl_addr SHALL wrap from 2^AW-1 to 0 with no flag.
REQ-024 ioctl_dout SHALL hold its value until the next write.
REQ-025 IGNORE SHALL consume bytes with no effect until SS2 goes high.
REQ-026 ioctl_download and ioctl_index SHALL persist across SS2 deassertion.
REQ-027 Latency: ioctl_wr SHALL rise exactly 4 clk cycles after the first clk edge that samples SPI_SCK high on bit 8.
REQ-028 Consecutive writes SHALL be at least 2 SCK periods apart by construction; no back-pressure exists.

Reset
REQ-029 While rst=1 at a clk edge: ioctl_download=0, ioctl_index=0, ioctl_addr=0, ioctl_dout=0, ioctl_wr=0, bit counter=0, FSM=CMD, synchronisers=idle (SCK 0, SS2 1).
REQ-030 rst mid-byte or mid-download SHALL abort it fully; the next byte is decoded only after SS2 goes high then low.

Verification
REQ-031 rst pulse with SS2 low and SCK toggling -> all outputs 0; no ioctl_wr during or after reset.
REQ-032 Frame 0x53,0x01; SS2 high -> ioctl_download=1, ioctl_addr=0, no ioctl_wr.
REQ-033 Then frame 0x54,0xA5,0x3C,0xFF -> three ioctl_wr pulses, (addr,dout)=(0,A5),(1,3C),(2,FF); each 4 clk after the 8th SCK rise; final ioctl_addr=3.
REQ-034 Frame 0x55,0x02 then 0x53,0x00 -> ioctl_index=0x02, ioctl_download=0, ioctl_addr stays 3; then 0x54,0x11 -> no ioctl_wr.
REQ-035 SS2 rises after 5 bits of a DAT byte -> no ioctl_wr; next frame 0x55,0x07 -> ioctl_index=0x07.
REQ-036 AW=4: 0x53,0x01 then 17 data bytes -> 17th write at addr 0, final ioctl_addr=1; unknown command 0x99,0x54,0x01 -> no effect.

Source files
------------

// File: rtl/spi_rom_rx.sv
// ============================================================================
//  Module   : spi_rom_rx
//  Purpose  : SPI-fed ROM download receiver driving an ioctl byte-write port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module spi_rom_rx #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SPI_SCK,
    input  logic          SPI_DI,
    input  logic          SPI_SS2,
    output logic          ioctl_download,
    output logic [7:0]    ioctl_index,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic          ioctl_wr
);

    localparam logic [7:0] c_FILE_TX     = 8'h53;
    localparam logic [7:0] c_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] c_FILE_INDEX  = 8'h55;

    typedef enum logic [2:0] {
        ST_CMD     = 3'd0,
        ST_TX_ARG  = 3'd1,
        ST_DAT     = 3'd2,
        ST_IDX_ARG = 3'd3,
        ST_IGNORE  = 3'd4
    } state_t;

    logic          r_sck_s1, r_sck_s2, r_sck_d;
    logic          r_di_s1, r_di_s2, r_di_d;
    logic          r_ss_s1, r_ss_s2;
    logic          r_rise;
    logic [1:0]    r_flush;
    logic          r_armed;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_byte_vld;
    logic [7:0]    r_byte;
    state_t        r_state;
    logic          r_download;
    logic [7:0]    r_index;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_dout;
    logic          r_wr;

    // Input synchronisers plus a registered SCK rise detector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_d  <= 1'b0;
            r_di_s1  <= 1'b0;
            r_di_s2  <= 1'b0;
            r_di_d   <= 1'b0;
            r_ss_s1  <= 1'b1;
            r_ss_s2  <= 1'b1;
            r_rise   <= 1'b0;
        end else begin
            r_sck_s1 <= SPI_SCK;
            r_sck_s2 <= r_sck_s1;
            r_sck_d  <= r_sck_s2;
            r_di_s1  <= SPI_DI;
            r_di_s2  <= r_di_s1;
            r_di_d   <= r_di_s2;
            r_ss_s1  <= SPI_SS2;
            r_ss_s2  <= r_ss_s1;
            r_rise   <= r_sck_s2 & ~r_sck_d;
        end
    end

    // After reset the synchroniser still holds its idle value for two edges;
    // r_flush keeps that stale "SS2 high" from arming the receiver.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush    <= 2'b11;
            r_armed    <= 1'b0;
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'h00;
            r_byte_vld <= 1'b0;
            r_byte     <= 8'h00;
        end else begin
            r_flush    <= {r_flush[0], 1'b0};
            r_byte_vld <= 1'b0;
            if (r_ss_s2) begin
                r_bitcnt <= 3'd0;
                if (r_flush == 2'b00) begin
                    r_armed <= 1'b1;
                end
            end else if (r_rise && r_armed) begin
                r_shift  <= {r_shift[6:0], r_di_d};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    r_byte_vld <= 1'b1;
                    r_byte     <= {r_shift[6:0], r_di_d};
                end
            end
        end
    end

    // Frame decoder; address advances on the clk after each write pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CMD;
            r_download <= 1'b0;
            r_index    <= 8'h00;
            r_addr     <= '0;
            r_dout     <= 8'h00;
            r_wr       <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            if (r_wr) begin
                r_addr <= r_addr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (r_ss_s2) begin
                r_state <= ST_CMD;
            end else if (r_byte_vld) begin
                case (r_state)
                    ST_CMD: begin
                        if (r_byte == c_FILE_TX)          r_state <= ST_TX_ARG;
                        else if (r_byte == c_FILE_TX_DAT) r_state <= ST_DAT;
                        else if (r_byte == c_FILE_INDEX)  r_state <= ST_IDX_ARG;
                        else                              r_state <= ST_IGNORE;
                    end
                    ST_TX_ARG: begin
                        if (r_byte != 8'h00) begin
                            r_download <= 1'b1;
                            r_addr     <= '0;
                        end else begin
                            r_download <= 1'b0;
                        end
                        r_state <= ST_IGNORE;
                    end
                    ST_IDX_ARG: begin
                        r_index <= r_byte;
                        r_state <= ST_IGNORE;
                    end
                    ST_DAT: begin
                        if (r_download) begin
                            r_dout <= r_byte;
                            r_wr   <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IGNORE;
                endcase
            end
        end
    end

    assign ioctl_download = r_download;
    assign ioctl_index    = r_index;
    assign ioctl_addr     = r_addr;
    assign ioctl_dout     = r_dout;
    assign ioctl_wr       = r_wr;

endmodule

`default_nettype wire
